// File: rtl/eth_mac_conf_pkg.sv
// Shared definitions for the MAC configuration controller: register map,
// flag bit indices, configuration-vector field positions, FSM states and packer.
package eth_mac_conf_pkg;

  localparam logic [1:0] ADDR_MAC_LO  = 2'd0;
  localparam logic [1:0] ADDR_MAC_HI  = 2'd1;
  localparam logic [1:0] ADDR_MAX_LEN = 2'd2;
  localparam logic [1:0] ADDR_FLAGS   = 2'd3;

  localparam int FLG_TX_EN        = 0;
  localparam int FLG_RX_EN        = 1;
  localparam int FLG_VLAN         = 2;
  localparam int FLG_JUMBO        = 3;
  localparam int FLG_TX_DIC       = 4;
  localparam int FLG_RX_FLCHK_DIS = 5;
  localparam int FLG_RX_LTCHK_DIS = 6;

  localparam logic [6:0] FLG_EN_MASK = 7'b000_0011;

  localparam int MAC_LSB          = 32;
  localparam int LEN_LSB          = 16;
  localparam int VEC_TX_DIC       = 10;
  localparam int VEC_RX_FLCHK_DIS = 9;
  localparam int VEC_RX_LTCHK_DIS = 8;
  localparam int VEC_JUMBO        = 4;
  localparam int VEC_VLAN         = 2;
  localparam int VEC_EN           = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    APPLY  = 3'd2,
    SETTLE = 3'd3,
    ENABLE = 3'd4
  } conf_state_t;

  function automatic logic [79:0] pack_vec(input logic [47:0] mac,
                                           input logic [14:0] len,
                                           input logic [6:0]  flags,
                                           input logic        is_rx);
    logic [79:0] v;
    v = '0;
    v[MAC_LSB +: 48]  = mac;
    v[LEN_LSB +: 15]  = len;
    v[VEC_JUMBO]      = flags[FLG_JUMBO];
    v[VEC_VLAN]       = flags[FLG_VLAN];
    if (is_rx) begin
      v[VEC_EN]           = flags[FLG_RX_EN];
      v[VEC_RX_FLCHK_DIS] = flags[FLG_RX_FLCHK_DIS];
      v[VEC_RX_LTCHK_DIS] = flags[FLG_RX_LTCHK_DIS];
    end else begin
      v[VEC_EN]           = flags[FLG_TX_EN];
      v[VEC_TX_DIC]       = flags[FLG_TX_DIC];
    end
    return v;
  endfunction

endpackage

// File: rtl/eth_mac_conf_ctrl.sv
// Runtime TX/RX configuration-vector controller with a safe commit sequence.
// Optional drain timeout with sticky error: define CONF_TIMEOUT_EN.
module eth_mac_conf_ctrl
  import eth_mac_conf_pkg::*;
#(
  parameter logic [47:0] SRC_MAC       = 48'h001122334455,
  parameter int          MAX_FRAME_LEN = 1518,
  parameter logic [6:0]  DEFAULT_FLAGS = 7'h7F,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          DRAIN_TIMEOUT = 1024
) (
  input  logic        clk156,
  input  logic        rst156_n,
  input  logic        cfg_wr_en,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wr_data,
  input  logic        cfg_commit,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  input  logic        mac_tx_busy,
  input  logic        mac_rx_busy,
  output logic [79:0] mac_tx_configuration_vector,
  output logic [79:0] mac_rx_configuration_vector
);

  localparam logic [14:0] RST_LEN     = 15'(MAX_FRAME_LEN);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [79:0] RST_TX_VEC  = pack_vec(SRC_MAC, RST_LEN, DEFAULT_FLAGS, 1'b0);
  localparam logic [79:0] RST_RX_VEC  = pack_vec(SRC_MAC, RST_LEN, DEFAULT_FLAGS, 1'b1);

  conf_state_t r_state;
  conf_state_t w_state_nxt;
  logic        w_commit_ok;

  logic [47:0] r_shd_mac;
  logic [14:0] r_shd_len;
  logic [6:0]  r_shd_flags;
  logic [47:0] r_act_mac;
  logic [14:0] r_act_len;
  logic [6:0]  r_act_flags;
  logic [7:0]  r_settle_cnt;
  logic [79:0] r_tx_vec;
  logic [79:0] r_rx_vec;
  logic        r_busy;
  logic        r_done;

  logic        w_drain_idle;
  logic [6:0]  w_act_flags_off;
  logic [6:0]  w_shd_flags_off;

  assign w_drain_idle    = !mac_tx_busy && !mac_rx_busy;
  assign w_act_flags_off = r_act_flags & ~FLG_EN_MASK;
  assign w_shd_flags_off = r_shd_flags & ~FLG_EN_MASK;

`ifdef CONF_TIMEOUT_EN
  localparam logic [15:0] DRAIN_LIMIT = 16'(DRAIN_TIMEOUT - 1);
  logic [15:0] r_drain_cnt;
  logic        r_err;
  logic        w_timeout;
`endif

  always_ff @(posedge clk156 or negedge rst156_n) begin
    if (!rst156_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit_ok = 1'b0;
`ifdef CONF_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (cfg_commit) begin
          w_state_nxt = DRAIN;
          w_commit_ok = 1'b1;
        end
      end
      DRAIN: begin
        if (w_drain_idle) begin
          w_state_nxt = APPLY;
        end
`ifdef CONF_TIMEOUT_EN
        // Give up on the drain: keep the old configuration and re-enable.
        else if (r_drain_cnt == DRAIN_LIMIT) begin
          w_state_nxt = ENABLE;
          w_timeout   = 1'b1;
        end
`endif
      end
      APPLY:   w_state_nxt = SETTLE;
      SETTLE:  if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ENABLE;
      ENABLE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk156 or negedge rst156_n) begin
    if (!rst156_n) begin
      r_shd_mac    <= SRC_MAC;
      r_shd_len    <= RST_LEN;
      r_shd_flags  <= DEFAULT_FLAGS;
      r_act_mac    <= SRC_MAC;
      r_act_len    <= RST_LEN;
      r_act_flags  <= DEFAULT_FLAGS;
      r_settle_cnt <= '0;
      r_tx_vec     <= RST_TX_VEC;
      r_rx_vec     <= RST_RX_VEC;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // Host writes only land while idle, so the shadow is stable during a sequence.
      if (r_state == IDLE && cfg_wr_en) begin
        case (cfg_addr)
          ADDR_MAC_LO:  r_shd_mac[31:0]  <= cfg_wr_data;
          ADDR_MAC_HI:  r_shd_mac[47:32] <= cfg_wr_data[15:0];
          ADDR_MAX_LEN: r_shd_len        <= cfg_wr_data[14:0];
          default:      r_shd_flags      <= cfg_wr_data[6:0];
        endcase
      end

      if (r_state == SETTLE && r_settle_cnt != SETTLE_LAST) r_settle_cnt <= r_settle_cnt + 8'd1;
      else                                                  r_settle_cnt <= '0;

      if (r_state == APPLY) begin
        r_act_mac   <= r_shd_mac;
        r_act_len   <= r_shd_len;
        r_act_flags <= r_shd_flags;
      end

      // Vectors only move on transitions: gate enables, load new fields, re-enable.
      if (r_state == IDLE && w_state_nxt == DRAIN) begin
        r_tx_vec <= pack_vec(r_act_mac, r_act_len, w_act_flags_off, 1'b0);
        r_rx_vec <= pack_vec(r_act_mac, r_act_len, w_act_flags_off, 1'b1);
      end else if (r_state == APPLY) begin
        r_tx_vec <= pack_vec(r_shd_mac, r_shd_len, w_shd_flags_off, 1'b0);
        r_rx_vec <= pack_vec(r_shd_mac, r_shd_len, w_shd_flags_off, 1'b1);
      end else if (r_state != ENABLE && w_state_nxt == ENABLE) begin
        r_tx_vec <= pack_vec(r_act_mac, r_act_len, r_act_flags, 1'b0);
        r_rx_vec <= pack_vec(r_act_mac, r_act_len, r_act_flags, 1'b1);
      end

      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == ENABLE);
    end
  end

`ifdef CONF_TIMEOUT_EN
  always_ff @(posedge clk156 or negedge rst156_n) begin
    if (!rst156_n) begin
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state != DRAIN)                r_drain_cnt <= '0;
      else if (r_drain_cnt != DRAIN_LIMIT) r_drain_cnt <= r_drain_cnt + 16'd1;

      if (w_commit_ok)    r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
    end
  end

  assign cfg_err = r_err;
`else
  assign cfg_err = 1'b0;
`endif

  assign cfg_busy                    = r_busy;
  assign cfg_done                    = r_done;
  assign mac_tx_configuration_vector = r_tx_vec;
  assign mac_rx_configuration_vector = r_rx_vec;

endmodule

// File: tb/tb_eth_mac_conf_ctrl.sv
// Scoreboard bench for eth_mac_conf_ctrl: stimulus queues the expected result of
// every completed commit; a monitor checks it when cfg_done pulses.
module tb_eth_mac_conf_ctrl;

  logic        clk156 = 1'b0;
  logic        rst156_n;
  logic        cfg_wr_en;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_commit;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic        mac_tx_busy;
  logic        mac_rx_busy;
  logic [79:0] mac_tx_configuration_vector;
  logic [79:0] mac_rx_configuration_vector;

  always #5 clk156 = ~clk156;

  eth_mac_conf_ctrl dut (
    .clk156                      (clk156),
    .rst156_n                    (rst156_n),
    .cfg_wr_en                   (cfg_wr_en),
    .cfg_addr                    (cfg_addr),
    .cfg_wr_data                 (cfg_wr_data),
    .cfg_commit                  (cfg_commit),
    .cfg_busy                    (cfg_busy),
    .cfg_done                    (cfg_done),
    .cfg_err                     (cfg_err),
    .mac_tx_busy                 (mac_tx_busy),
    .mac_rx_busy                 (mac_rx_busy),
    .mac_tx_configuration_vector (mac_tx_configuration_vector),
    .mac_rx_configuration_vector (mac_rx_configuration_vector)
  );

  typedef struct {
    logic [79:0] tx;
    logic [79:0] rx;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  localparam logic [47:0] DEF_MAC   = 48'h001122334455;
  localparam logic [14:0] DEF_LEN   = 15'd1518;
  localparam logic [6:0]  DEF_FLAGS = 7'h7F;
  localparam logic [79:0] RST_TX    = {48'h001122334455, 1'b0, 15'd1518, 16'h0416};
  localparam logic [79:0] RST_RX    = {48'h001122334455, 1'b0, 15'd1518, 16'h0316};

  // Shadow (s_) and active (a_) configuration as the bench expects them.
  logic [47:0] s_mac, a_mac;
  logic [14:0] s_len, a_len;
  logic [6:0]  s_flags, a_flags;

  always @(posedge clk156) cyc <= cyc + 1;

  function automatic logic [79:0] tx_model(logic [47:0] m, logic [14:0] l, logic [6:0] f);
    return {m, 1'b0, l, 5'b0, f[4], 5'b0, f[3], 1'b0, f[2], f[0], 1'b0};
  endfunction

  function automatic logic [79:0] rx_model(logic [47:0] m, logic [14:0] l, logic [6:0] f);
    return {m, 1'b0, l, 6'b0, f[5], f[6], 3'b0, f[3], 1'b0, f[2], f[1], 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_wr_en   = 1'b1;
    cfg_addr    = a;
    cfg_wr_data = d;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic model_wr(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0:    s_mac[31:0]  = d;
      2'd1:    s_mac[47:32] = d[15:0];
      2'd2:    s_len        = d[14:0];
      default: s_flags      = d[6:0];
    endcase
  endtask

  task automatic push_apply(input int done_cyc);
    exp_t e;
    a_mac = s_mac; a_len = s_len; a_flags = s_flags;
    e.tx = tx_model(a_mac, a_len, a_flags);
    e.rx = rx_model(a_mac, a_len, a_flags);
    e.err = 1'b0;
    e.cyc = done_cyc;
    q.push_back(e);
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  // Monitor: every cfg_done must match the oldest queued expectation.
  always @(negedge clk156) begin
    if (rst156_n && cfg_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 80'(cfg_done), 80'(1'b0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", 80'(cyc), 80'(e.cyc));
        chk("done_tx_vec", mac_tx_configuration_vector, e.tx);
        chk("done_rx_vec", mac_rx_configuration_vector, e.rx);
        chk("done_err", 80'(cfg_err), 80'(e.err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst156_n    = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_addr    = '0;
    cfg_wr_data = '0;
    cfg_commit  = 1'b0;
    mac_tx_busy = 1'b0;
    mac_rx_busy = 1'b0;
    s_mac = DEF_MAC; s_len = DEF_LEN; s_flags = DEF_FLAGS;
    a_mac = DEF_MAC; a_len = DEF_LEN; a_flags = DEF_FLAGS;

    // Reset state
    repeat (3) tick();
    chk("rst_tx_vec", mac_tx_configuration_vector, RST_TX);
    chk("rst_rx_vec", mac_rx_configuration_vector, RST_RX);
    rst156_n = 1'b1;
    tick();
    chk("rst_tx_after", mac_tx_configuration_vector, RST_TX);
    chk("rst_rx_after", mac_rx_configuration_vector, RST_RX);
    chk("rst_busy_done_err", {cfg_busy, cfg_done, cfg_err}, 3'b000);

    // Jumbo length, full flags, busy inputs low: done at commit+7
    wr(2'd2, 32'd9000); model_wr(2'd2, 32'd9000);
    wr(2'd3, 32'h7F);   model_wr(2'd3, 32'h7F);
    c = cyc;
    push_apply(c + 7);
    commit();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk156);
      chk("seq_enables_off", {mac_tx_configuration_vector[1], mac_rx_configuration_vector[1], cfg_busy}, 3'b001);
      if (i == 4) chk("settle_len", 80'(mac_tx_configuration_vector[30:16]), 80'(15'd9000));
    end
    @(negedge clk156);
    chk("enable_bits_on", {mac_tx_configuration_vector[1], mac_rx_configuration_vector[1]}, 2'b11);
    tick();
    tick();
    chk("idle_after_done", {cfg_busy, cfg_done}, 2'b00);

    // TX busy holds DRAIN; a write while busy is dropped
    mac_tx_busy = 1'b1;
    commit();
    wr(2'd0, 32'hDEADBEEF);
    repeat (18) tick();
    @(negedge clk156);
    chk("drain_hold", {mac_tx_configuration_vector[1], mac_rx_configuration_vector[1], cfg_busy, cfg_done}, 4'b0010);
    chk("drain_vec_mac", mac_tx_configuration_vector[79:32], s_mac);
    tick();
    mac_tx_busy = 1'b0;
    c = cyc;
    push_apply(c + 6);
    repeat (8) tick();

    // New flag pattern; write and commit in the same idle cycle
    wr(2'd3, 32'h2A);      model_wr(2'd3, 32'h2A);
    wr(2'd1, 32'h0000CAFE); model_wr(2'd1, 32'h0000CAFE);
    cfg_wr_en = 1'b1; cfg_addr = 2'd0; cfg_wr_data = 32'hDEADBEEF;
    model_wr(2'd0, 32'hDEADBEEF);
    c = cyc;
    push_apply(c + 7);
    commit();
    cfg_wr_en = 1'b0;
    repeat (9) tick();
    chk("idle_tx_2a", mac_tx_configuration_vector, tx_model(48'hCAFEDEADBEEF, 15'd9000, 7'h2A));

    // Asynchronous reset during SETTLE: reset outputs, no done pulse
    commit();
    repeat (3) tick();
    #2 rst156_n = 1'b0;
    #1;
    chk("midrst_tx_vec", mac_tx_configuration_vector, RST_TX);
    chk("midrst_rx_vec", mac_rx_configuration_vector, RST_RX);
    chk("midrst_flags", {cfg_busy, cfg_done, cfg_err}, 3'b000);
    s_mac = DEF_MAC; s_len = DEF_LEN; s_flags = DEF_FLAGS;
    a_mac = DEF_MAC; a_len = DEF_LEN; a_flags = DEF_FLAGS;
    tick();
    rst156_n = 1'b1;
    repeat (12) tick();

    // Shadow was reset too: a bare commit reapplies the defaults
    c = cyc;
    push_apply(c + 7);
    commit();
    repeat (9) tick();

`ifdef CONF_TIMEOUT_EN
    begin
      exp_t e;
      wr(2'd2, 32'd64); model_wr(2'd2, 32'd64);
      mac_rx_busy = 1'b1;
      c = cyc;
      e.tx = tx_model(a_mac, a_len, a_flags);
      e.rx = rx_model(a_mac, a_len, a_flags);
      e.err = 1'b1;
      e.cyc = c + 1025;
      q.push_back(e);
      commit();
      repeat (1026) tick();
      chk("timeout_err_sticky", 80'(cfg_err), 80'(1'b1));
      mac_rx_busy = 1'b0;
      c = cyc;
      push_apply(c + 7);
      commit();
      @(negedge clk156);
      chk("commit_clears_err", 80'(cfg_err), 80'(1'b0));
      repeat (9) tick();
    end
`endif

    repeat (4) tick();
    chk("pending_done", 80'(q.size()), 80'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_mac_conf_ctrl.md
Name: eth_mac_conf_ctrl

Overview:
Runtime controller for the 10G MAC TX/RX configuration vectors. It holds shadow configuration registers, written over a simple register port. On a commit it sequences a safe reconfiguration: disable TX/RX, drain, load the new vectors, settle, then re-enable. It sits between the host register block and the MAC core, and drives mac_tx_configuration_vector and mac_rx_configuration_vector in place of static tie-offs.

Parameters:
- SRC_MAC, 48'h001122334455, reset MAC address (vector bits [79:32]).
- MAX_FRAME_LEN, 1518, reset max frame length (vector bits [30:16], 15-bit).
- DEFAULT_FLAGS, 7'h7F, reset value of the flag register (map below).
- SETTLE_CYCLES, 4, cycles spent in SETTLE (≥1, 8-bit counter).
- DRAIN_TIMEOUT, 1024, DRAIN timeout in cycles (16-bit counter; used only with CONF_TIMEOUT_EN).

Ports:
- clk156, input, 1, 156.25 MHz MAC clock.
- rst156_n, input, 1, asynchronous active-low reset.
- cfg_wr_en, input, 1, shadow register write strobe.
- cfg_addr, input, 2, register select: 0 = MAC[31:0], 1 = MAC[47:32] (data[15:0]), 2 = max frame length (data[14:0]), 3 = flags (data[6:0]).
- cfg_wr_data, input, 32, write data.
- cfg_commit, input, 1, one-cycle pulse requesting apply.
- cfg_busy, output, 1, high in every state except IDLE.
- cfg_done, output, 1, one-cycle pulse at sequence end.
- cfg_err, output, 1, sticky drain-timeout flag.
- mac_tx_busy, input, 1, MAC TX frame in flight.
- mac_rx_busy, input, 1, MAC RX frame in flight.
- mac_tx_configuration_vector, output, 80, active TX configuration.
- mac_rx_configuration_vector, output, 80, active RX configuration.

Behaviour:
- Flag map: b0 tx_en, b1 rx_en, b2 vlan, b3 jumbo, b4 tx DIC, b5 rx frame-length-check disable, b6 rx length/type-check disable.
- TX vector fields: [79:32] MAC, [30:16] len, [10] DIC, [4] jumbo, [2] vlan, [1] tx_en.
- RX vector fields: [79:32] MAC, [30:16] len, [9] b5, [8] b6, [4] jumbo, [2] vlan, [1] rx_en.
- All other vector bits are always 0.
- Reset:
  - Shadow and active registers load SRC_MAC, MAX_FRAME_LEN and DEFAULT_FLAGS.
  - Outputs reflect those values immediately.
  - cfg_busy = 0, cfg_done = 0, cfg_err = 0, state = IDLE, counters = 0.
- Writes are accepted only in IDLE; writes while busy are dropped silently.
- Reset mid-sequence returns every register to its reset value.
- FSM:
  - IDLE: cfg_commit → DRAIN. If cfg_wr_en and cfg_commit arrive in the same cycle, the write lands first and the commit uses the updated shadow. A commit while busy is ignored. An accepted commit clears cfg_err.
  - DRAIN: active tx_en and rx_en bits are forced to 0 from the first DRAIN cycle. Exit to APPLY on the first cycle where mac_tx_busy = 0 and mac_rx_busy = 0.
  - APPLY (1 cycle): copy the shadow into the active registers, with the enable bits still held at 0.
  - SETTLE: exactly SETTLE_CYCLES cycles, counter 0..SETTLE_CYCLES-1, then → ENABLE.
  - ENABLE (1 cycle): enable bits take the active flag values, cfg_done = 1, → IDLE.
- Latency: with busy inputs low, a commit in cycle N gives cfg_done in cycle N+3+SETTLE_CYCLES (N+7 at default).
- Outputs are registered, and the vectors change only on state transitions.

Optional Feature:
- Macro: CONF_TIMEOUT_EN.
- When defined:
  - A DRAIN cycle counter runs.
  - If DRAIN_TIMEOUT cycles elapse with either busy input high: set cfg_err, skip APPLY/SETTLE and go to ENABLE.
  - ENABLE restores the previous active values, shadow not applied, and cfg_done still pulses.
  - The counter clears on DRAIN entry.
- When undefined:
  - DRAIN waits indefinitely.
  - cfg_err is tied to 0 and no counter logic is present.

Decomposition:
- Package eth_mac_conf_pkg holds:
  - register address localparams.
  - flag bit indices.
  - vector field positions (MAC_LSB, LEN_LSB, and bits 10/9/8/4/2/1).
  - the state enum (IDLE, DRAIN, APPLY, SETTLE, ENABLE).
  - a vector-pack function (mac, len, flags, is_rx).
- No sub-module: FSM, shadow registers and counters stay in one file.

Test Plan:
- Reset: TX vector = {48'h001122334455, 1'b0, 15'd1518, 16'h0416}; RX vector = {48'h001122334455, 1'b0, 15'd1518, 16'h0316}; busy/done/err all 0.
- Write addr2 = 9000 and addr3 = 7'h7F, then commit with busy inputs low → cfg_done at commit+7 and vector [30:16] = 9000. During DRAIN through SETTLE, bit[1] = 0 in both vectors; bit[1] returns to 1 in ENABLE.
- Hold mac_tx_busy = 1 for 20 cycles after a commit → state stays DRAIN with enables at 0. Busy falls in cycle k → APPLY in k, cfg_done in k+1+SETTLE_CYCLES.
- Write addr0 = 32'hDEADBEEF while busy → dropped. Write and commit in the same IDLE cycle → the new value is applied.
- Assert rst156_n low during SETTLE → all outputs return to their reset values asynchronously, and there is no cfg_done pulse.
- With CONF_TIMEOUT_EN and mac_rx_busy stuck high → cfg_err rises after 1024 DRAIN cycles, the old vectors are restored, cfg_done pulses, and the next accepted commit clears cfg_err.
